// File: rtl/bip_fetch.sv
// BIP instruction fetch/sequencing stage: PC, instruction register, run/step control and execute strobe.
// Each instruction takes three cycles: issue the read, latch the IR, then execute.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | PC on o_PmAddr; a read is issued when run permission (go) holds
// S_LOAD  | memory data valid; latch it into the IR
// S_EXEC  | o_Exec high; apply the decoder's WrPC/Halt and count the instruction
// S_HALT  | HLT executed; only reset leaves this state
module bip_fetch #(
    parameter int PC_W    = 11,
    parameter int OPCODE  = 5,
    parameter int OPERAND = 11,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_Enable,
    input  logic               i_StepMode,
    input  logic               i_Step,
    input  logic [INSTR_W-1:0] i_PmData,
    input  logic               i_WrPC,
    input  logic               i_Halt,
    output logic [PC_W-1:0]    o_PmAddr,
    output logic               o_PmRdEn,
    output logic [OPCODE-1:0]  o_Opcode,
    output logic [OPERAND-1:0] o_Operand,
    output logic               o_Exec,
    output logic [PC_W-1:0]    o_PC,
    output logic               o_Halted,
    output logic [CNT_W-1:0]   o_InstrCnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_step_q;
    logic                w_go;
    logic                w_rden;
    logic                w_exec;
    logic                w_halted;

    // A held i_Step yields a single go; edges seen outside FETCH are swallowed by r_step_q.
    assign w_go = i_Enable & (~i_StepMode | (i_Step & ~r_step_q));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_cnt    <= '0;
            r_step_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_step_q <= i_Step;
            if (r_state == S_LOAD) begin
                r_ir <= i_PmData;
            end
            if ((r_state == S_EXEC) && !i_Halt) begin
                if (i_WrPC) begin
                    r_pc <= r_pc + PC_W'(1);
                end
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rden      = 1'b0;
        w_exec      = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_go) begin
                    w_rden      = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = i_Halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // The read enable is combinational from i_Enable, so hold it low while reset is asserted.
    assign o_PmRdEn   = w_rden & i_rst_n;
    assign o_Exec     = w_exec;
    assign o_Halted   = w_halted;
    assign o_PmAddr   = r_pc;
    assign o_PC       = r_pc;
    assign o_InstrCnt = r_cnt;
    assign o_Opcode   = r_ir[INSTR_W-1 -: OPCODE];
    assign o_Operand  = r_ir[OPERAND-1:0];

endmodule

// File: doc/bip_fetch.md
Name: bip_fetch

Overview:
- Instruction-fetch and sequencing stage of the BIP processor; sits directly upstream of the opcode decoder.
- Holds the PC and reads 16-bit instructions from synchronous program memory. Latches each instruction into an instruction register (IR) and presents opcode/operand to the decoder.
- Consumes the decoder's o_WrPC/o_Halt, emits a one-cycle execute strobe that qualifies all datapath and RAM writes, and supports run/single-step control.

Parameters:
- PC_W, 11, program counter / program memory address width
- OPCODE, 5, opcode field width (IR[15:11])
- OPERAND, 11, operand field width (IR[10:0])
- INSTR_W, 16, instruction width; must equal OPCODE+OPERAND
- CNT_W, 16, executed-instruction counter width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_Enable  in  1  run permission; 0 stalls in FETCH
- i_StepMode  in  1  1 = advance one instruction per i_Step rising edge
- i_Step  in  1  step request, level; edge-detected internally
- i_PmData  in  INSTR_W  program memory read data, valid the cycle after o_PmRdEn
- i_WrPC  in  1  from decoder: increment PC after this instruction
- i_Halt  in  1  from decoder: HLT decoded
- o_PmAddr  out  PC_W  program memory address, always equal to PC
- o_PmRdEn  out  1  program memory read enable
- o_Opcode  out  OPCODE  IR[15:11], to decoder
- o_Operand  out  OPERAND  IR[10:0], to datapath/RAM address
- o_Exec  out  1  decoded controls valid; gates WrAcc/WrRam/WrPC
- o_PC  out  PC_W  current PC (debug)
- o_Halted  out  1  processor halted
- o_InstrCnt  out  CNT_W  count of executed non-HLT instructions

Behaviour:
- Reset (async assert, sync release): state=FETCH, PC=0, IR=0, step_q=0, o_PmRdEn=0, o_Exec=0, o_Halted=0, o_InstrCnt=0.
- FSM states: FETCH, LOAD, EXEC, HALT.
- go = i_Enable & (~i_StepMode | (i_Step & ~step_q)). step_q registers i_Step every cycle in all states.
- FETCH:
  - o_PmRdEn = go (combinational).
  - go=1 -> LOAD.
  - go=0 -> stay; no read issued.
- LOAD: IR <= i_PmData; -> EXEC.
- EXEC:
  - o_Exec=1 for exactly this cycle.
  - o_Opcode/o_Operand are stable from IR.
  - i_Halt=1 -> HALT; PC and count unchanged.
  - Otherwise:
    - if i_WrPC=1, PC <= PC+1, modulo 2^PC_W (2047 -> 0).
    - if i_WrPC=0, PC holds; the same address is re-fetched.
    - o_InstrCnt += 1, saturating at 2^CNT_W-1.
    - -> FETCH.
- HALT: o_Halted=1; o_Exec=0 and o_PmRdEn=0 permanently. Only reset exits; i_Enable and i_Step are ignored.
- Latency: 3 cycles per instruction at go=1 continuously. Address is issued on cycle n, IR loads on n+1, o_Exec on n+2.
- o_Opcode/o_Operand change only on the LOAD->EXEC edge and are held through stalls.
- o_Exec=0 in FETCH/LOAD/HALT. The decoder output is ignored outside EXEC; the IR reset value (opcode 0 = HLT) must not halt before the first EXEC.
- i_Enable deasserted in LOAD or EXEC: the instruction completes, then the block stalls in FETCH.
- Step edge arriving in LOAD/EXEC: it is consumed by step_q and not queued. A held i_Step yields exactly one instruction.
- i_StepMode toggled mid-instruction: takes effect at the next FETCH.
- Reset mid-instruction: immediate return to reset values. A pending memory read is discarded.

Test Plan:
- Free run: memory {LDI 5, ADDI 3, STO 7, HLT} with i_Enable=1, i_StepMode=0.
  - Required: o_Exec pulses at cycles 2, 5, 8, 11 after reset release; o_PmAddr 0,1,2,3.
  - Required: o_Halted=1 from cycle 12; o_InstrCnt=3; PC=3.
- Stall: i_Enable=0 for 10 cycles, then 1.
  - Required: o_PmRdEn=0 and state FETCH throughout; first o_Exec arrives 3 cycles after enable.
  - Required: drop i_Enable during LOAD -> the current o_Exec still occurs, then stall.
- Single-step: i_StepMode=1, i_Step held high 20 cycles.
  - Required: exactly one o_Exec, PC 0->1.
  - Required: a second 1-cycle pulse advances PC to 2; a pulse arriving during EXEC does not advance.
- Hold PC: decoder default opcode 5'b11111 (WrPC=0) at address 4.
  - Required: repeated fetches of address 4; o_InstrCnt increments each EXEC; PC stays 4.
- Wrap/saturate: PC_W=3, CNT_W=2, 10 ADDI instructions.
  - Required: o_PmAddr sequence 0..7,0,1.
  - Required: o_InstrCnt saturates at 3.
- Reset: assert i_rst_n=0 in EXEC, and separately in HALT.
  - Required: outputs return to reset values asynchronously in the same cycle; execution resumes from PC=0 after release.
